// File: rtl/io_pattern_monitor_pkg.sv
// Shared definitions for the io pattern monitor: FSM states, fail codes, masked compare helper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package io_pattern_monitor_pkg;

    // Widest bus the monitor is built for; the compare helper works at this width.
    localparam int MAX_WIDTH = 38;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_STABLE = 2'd2,
        ST_DONE   = 2'd3
    } mon_state_t;

    localparam logic [1:0] FAIL_NONE    = 2'b00;
    localparam logic [1:0] FAIL_TIMEOUT = 2'b01;
    localparam logic [1:0] FAIL_ORDER   = 2'b10;

    // True when every bit selected by mask agrees between value and pattern.
    // Callers zero-extend narrower buses, so the unused mask bits never compare.
    function automatic logic masked_eq(input logic [MAX_WIDTH-1:0] value,
                                       input logic [MAX_WIDTH-1:0] pattern,
                                       input logic [MAX_WIDTH-1:0] mask);
        return ((value ^ pattern) & mask) == '0;
    endfunction

endpackage

// File: rtl/io_mon_sync.sv
// io_mon_sync: WIDTH-wide flop chain bringing the asynchronous pad bus into the wb_clk_i domain.
// Latency: STAGES cycles (STAGES = 0 is a straight wire).
// Backpressure: none; samples every cycle.
module io_mon_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (STAGES == 0) begin : g_bypass
            assign dout = din;
        end else begin : g_chain
            logic [WIDTH-1:0] stage_q [STAGES];

            // Shift the pad value down the chain; reset clears every stage.
            always_ff @(posedge wb_clk_i) begin
                if (wb_rst_i) begin
                    for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
                end else begin
                    stage_q[0] <= din;
                    for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
                end
            end

            assign dout = stage_q[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/io_pattern_monitor.sv
// io_pattern_monitor: walks io_in through a programmed (pattern, mask) table and reports pass/timeout/order fail.
// Latency: SYNC_STAGES cycles pin-to-compare, then one cycle to the registered status outputs.
// Backpressure: none; io_in is observed every cycle, table writes are dropped while busy.
module io_pattern_monitor
    import io_pattern_monitor_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 16,
    parameter int AW            = 4,
    parameter int TW            = 24,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [WIDTH-1:0] io_in,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [WIDTH-1:0] cfg_pattern,
    input  logic [WIDTH-1:0] cfg_mask,
    input  logic [AW:0]      cfg_len,
    input  logic             cfg_strict,
    input  logic [TW-1:0]    timeout_cycles,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             pass,
    output logic             fail,
    output logic [1:0]       fail_code,
    output logic [AW-1:0]    step_idx,
    output logic             step_pulse
);

    localparam int              SCW       = $clog2(STABLE_CYCLES + 1);
    localparam logic [SCW-1:0]  SC_TARGET = SCW'(STABLE_CYCLES);
    localparam logic [AW:0]     DEPTH_L   = (AW+1)'(DEPTH);
    localparam logic [TW-1:0]   TCNT_MAX  = '1;

    logic [WIDTH-1:0] io_s;
    logic [WIDTH-1:0] pat_mem [DEPTH];
    logic [WIDTH-1:0] msk_mem [DEPTH];

    mon_state_t       state;
    logic [TW-1:0]    tcnt;
    logic [SCW-1:0]   scnt;
    logic [AW:0]      len_q;
    logic             strict_q;

    logic [AW-1:0]    prev_idx;
    logic [AW:0]      len_clamped;
    logic             in_run;
    logic             m_cur;
    logic             m_prev;
    logic [SCW-1:0]   scnt_inc;
    logic             accept;
    logic             last_step;
    logic             timeout_hit;
    logic             order_viol;
    logic [TW-1:0]    tcnt_inc;

    io_mon_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .din      (io_in),
        .dout     (io_s)
    );

    assign busy = (state == ST_WAIT) || (state == ST_STABLE);

    // Table write port; the table is deliberately left out of reset so a run can be reprogrammed cheaply.
    always_ff @(posedge wb_clk_i) begin
        if (cfg_we && !busy) begin
            pat_mem[cfg_addr] <= cfg_pattern;
            msk_mem[cfg_addr] <= cfg_mask;
        end
    end

    // Per-cycle step decisions: match, stability count, acceptance, timeout and ordering checks.
    always_comb begin
        prev_idx    = step_idx - AW'(1);
        len_clamped = (cfg_len > DEPTH_L) ? DEPTH_L : cfg_len;
        in_run      = busy;
        m_cur       = masked_eq(MAX_WIDTH'(io_s), MAX_WIDTH'(pat_mem[step_idx]),
                                MAX_WIDTH'(msk_mem[step_idx]));
        m_prev      = masked_eq(MAX_WIDTH'(io_s), MAX_WIDTH'(pat_mem[prev_idx]),
                                MAX_WIDTH'(msk_mem[prev_idx]));
        // A match seen from WAIT is the first stable cycle; from STABLE it extends the run.
        if (state == ST_STABLE) begin
            scnt_inc = (scnt == SC_TARGET) ? scnt : scnt + SCW'(1);
        end else begin
            scnt_inc = SCW'(1);
        end
        accept      = in_run && m_cur && (scnt_inc == SC_TARGET);
        last_step   = (({1'b0, step_idx} + (AW+1)'(1)) == len_q);
        timeout_hit = in_run && (timeout_cycles != '0) && (tcnt == timeout_cycles);
        // Still showing the previous step's value is legal; anything else while waiting is out of order.
        order_viol  = in_run && strict_q && (state == ST_WAIT) && (step_idx != '0) && !m_cur && !m_prev;
        tcnt_inc    = (tcnt == TCNT_MAX) ? tcnt : tcnt + TW'(1);
    end

    // Run sequencer: abort first, then acceptance, timeout and order fault in that priority.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= ST_IDLE;
            tcnt       <= '0;
            scnt       <= '0;
            len_q      <= '0;
            strict_q   <= 1'b0;
            pass       <= 1'b0;
            fail       <= 1'b0;
            fail_code  <= FAIL_NONE;
            step_idx   <= '0;
            step_pulse <= 1'b0;
        end else begin
            step_pulse <= 1'b0;
            if (abort) begin
                state     <= ST_IDLE;
                tcnt      <= '0;
                scnt      <= '0;
                pass      <= 1'b0;
                fail      <= 1'b0;
                fail_code <= FAIL_NONE;
                step_idx  <= '0;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (start) begin
                            pass      <= 1'b0;
                            fail      <= 1'b0;
                            fail_code <= FAIL_NONE;
                            step_idx  <= '0;
                            tcnt      <= '0;
                            scnt      <= '0;
                            len_q     <= len_clamped;
                            strict_q  <= cfg_strict;
                            if (len_clamped == '0) begin
                                pass  <= 1'b1;
                                state <= ST_DONE;
                            end else begin
                                state <= ST_WAIT;
                            end
                        end
                    end
                    ST_WAIT, ST_STABLE: begin
                        if (accept) begin
                            step_pulse <= 1'b1;
                            tcnt       <= '0;
                            scnt       <= '0;
                            if (last_step) begin
                                pass  <= 1'b1;
                                state <= ST_DONE;
                            end else begin
                                step_idx <= step_idx + AW'(1);
                                state    <= ST_WAIT;
                            end
                        end else if (timeout_hit) begin
                            fail      <= 1'b1;
                            fail_code <= FAIL_TIMEOUT;
                            state     <= ST_DONE;
                        end else if (order_viol) begin
                            fail      <= 1'b1;
                            fail_code <= FAIL_ORDER;
                            state     <= ST_DONE;
                        end else begin
                            tcnt <= tcnt_inc;
                            if (m_cur) begin
                                scnt  <= scnt_inc;
                                state <= ST_STABLE;
                            end else begin
                                scnt  <= '0;
                                state <= ST_WAIT;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
